ide_sector_sequencer: RTL

- Hardware engine that runs a multi-sector SD-card-to-IDE DMA read on its own, without the RISC-V stepping each sector.
- Masters the IDE interface register/buffer port and starts SD card sector fetches.
- Double-buffers the two IDE buffer banks: the next sector is prefetched into the inactive bank while the host DMA-reads the active bank.
- Muxes the CPU onto the same port when idle.

---
 rtl/ide_sector_sequencer.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ide_sector_sequencer.sv
// Multi-sector SD-to-IDE DMA read sequencer: fetches sectors from the SD card,
// arms the IDE buffer banks in ping-pong fashion and lends the IDE port to the CPU when idle.
module ide_sector_sequencer #(
  parameter logic [7:0] SECTOR_WORDS_M1 = 8'd255,
  parameter logic [7:0] STATUS_DRQ      = 8'h58,
  parameter logic [7:0] STATUS_DONE     = 8'h50,
  parameter int         TIMEOUT_W       = 20
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic [7:0]  count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sd_req,
  output logic [31:0] sd_lba,
  input  logic        sd_ack,
  input  logic        sd_done,
  input  logic        sd_error,
  output logic [10:0] ide_a,
  output logic [31:0] ide_d_out,
  output logic        ide_cs,
  output logic        ide_oe,
  output logic [3:0]  ide_wstrb,
  input  logic [31:0] ide_d_in,
  input  logic        ide_wait,
  input  logic [10:0] cpu_a,
  input  logic [31:0] cpu_d,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_wait
);

  typedef enum logic [4:0] {
    S_IDLE, S_SDCFG, S_SDREQ, S_SDWAIT,
    S_ARM0, S_ARM1, S_ARM2, S_ARM3,
    S_HWAIT, S_CLR, S_FLIP,
    S_FIN0, S_FIN1,
    S_ERR0, S_ERR1, S_ERR2,
    S_RET
  } state_t;

  localparam logic [3:0] IDX_STAT_IRQ = 4'd0;
  localparam logic [3:0] IDX_ERROR    = 4'd1;
  localparam logic [3:0] IDX_IOCTRL   = 4'd2;
  localparam logic [3:0] IDX_IOPOS    = 4'd3;
  localparam logic [3:0] IDX_STATUS   = 4'd4;
  localparam logic [3:0] IDX_IOTARGET = 4'd5;
  localparam logic [3:0] IDX_FLAGS    = 4'd6;

  state_t                 state_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;
  logic                   sd_req_r;
  logic [31:0]            sd_lba_r;
  logic [8:0]             rem_r;
  logic [31:0]            cur_lba_r;
  logic                   first_r;
  logic                   hdone_r;
  logic                   pdone_r;
  logic [TIMEOUT_W-1:0]   timer_r;
  logic [10:0]            eng_a_r;
  logic [31:0]            eng_d_r;
  logic                   eng_cs_r;
  logic                   eng_oe_r;
  logic [3:0]             eng_wstrb_r;

  logic                   wr_en_s;
  logic [3:0]             wr_idx_s;
  logic [7:0]             wr_dat_s;
  logic                   active_s;
  logic                   rd_busy_s;
  logic                   rd_fin_s;
  logic                   hd_s;
  logic                   pd_s;
  logic                   last_s;
  logic                   timer_run_s;
  logic                   timer_max_s;
  logic                   fault_s;
  logic                   hw_exit_s;
  logic                   issue_wr_s;
  logic                   rd_issue_s;
  logic                   rd_hold_s;
  logic                   unused_s;

  assign active_s    = (state_r == S_SDCFG) || (state_r == S_SDREQ) || (state_r == S_SDWAIT) ||
                       (state_r == S_ARM0)  || (state_r == S_ARM1)  || (state_r == S_ARM2)   ||
                       (state_r == S_ARM3)  || (state_r == S_HWAIT) || (state_r == S_CLR)    ||
                       (state_r == S_FLIP);
  assign rd_busy_s   = eng_cs_r & eng_oe_r;
  assign rd_fin_s    = rd_busy_s & ~ide_wait;
  assign hd_s        = hdone_r | (rd_fin_s & ide_d_in[5]);
  assign pd_s        = pdone_r | sd_done;
  assign last_s      = (rem_r == 9'd1);
  assign timer_max_s = &timer_r;
  assign timer_run_s = (state_r == S_SDWAIT) ||
                       ((state_r == S_HWAIT) && !pdone_r && (rem_r > 9'd1));
  // Abort is only honoured between reads so a held bus cycle is never cut short.
  assign fault_s     = active_s & (sd_error | (timer_run_s & timer_max_s) | (abort & ~rd_busy_s));
  assign hw_exit_s   = hd_s & (pd_s | last_s) & ~(rd_busy_s & ide_wait);
  assign issue_wr_s  = wr_en_s & ~fault_s;
  assign rd_issue_s  = (state_r == S_HWAIT) & ~rd_busy_s & ~fault_s & ~hw_exit_s;
  assign rd_hold_s   = (state_r == S_HWAIT) & rd_busy_s & ide_wait & ~fault_s;
  assign unused_s    = ^{ide_d_in[31:6], ide_d_in[4:0]};

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign sd_req    = sd_req_r;
  assign sd_lba    = sd_lba_r;
  assign ide_a     = busy_r ? eng_a_r     : cpu_a;
  assign ide_d_out = busy_r ? eng_d_r     : cpu_d;
  assign ide_cs    = busy_r ? eng_cs_r    : cpu_cs;
  assign ide_oe    = busy_r ? eng_oe_r    : cpu_oe;
  assign ide_wstrb = busy_r ? eng_wstrb_r : cpu_wstrb;
  assign cpu_wait  = busy_r ? cpu_cs      : ide_wait;

  // Register write issued by the current state (appears on the bus next cycle).
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = 4'd0;
    wr_dat_s = 8'h00;
    case (state_r)
      S_SDCFG: begin wr_en_s = 1'b1; wr_idx_s = IDX_IOCTRL;   wr_dat_s = first_r ? 8'h44 : 8'h46; end
      S_ARM0:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOPOS;    wr_dat_s = 8'h00;                   end
      S_ARM1:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOTARGET; wr_dat_s = SECTOR_WORDS_M1;         end
      S_ARM2:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOCTRL;   wr_dat_s = 8'h04;                   end
      S_ARM3:  begin wr_en_s = 1'b1; wr_idx_s = IDX_STATUS;   wr_dat_s = STATUS_DRQ;              end
      S_CLR:   begin wr_en_s = 1'b1; wr_idx_s = IDX_FLAGS;    wr_dat_s = 8'h20;                   end
      S_FLIP:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOCTRL;   wr_dat_s = 8'h80;                   end
      S_FIN0:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOCTRL;   wr_dat_s = 8'h00;                   end
      S_FIN1:  begin wr_en_s = 1'b1; wr_idx_s = IDX_STAT_IRQ; wr_dat_s = STATUS_DONE;             end
      S_ERR0:  begin wr_en_s = 1'b1; wr_idx_s = IDX_ERROR;    wr_dat_s = 8'h04;                   end
      S_ERR1:  begin wr_en_s = 1'b1; wr_idx_s = IDX_IOCTRL;   wr_dat_s = 8'h00;                   end
      S_ERR2:  begin wr_en_s = 1'b1; wr_idx_s = IDX_STAT_IRQ; wr_dat_s = STATUS_DONE | 8'h01;     end
      default: begin wr_en_s = 1'b0; wr_idx_s = 4'd0;         wr_dat_s = 8'h00;                   end
    endcase
  end

  // Engine-side IDE bus registers: one-cycle writes, reads held through wait states.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      eng_a_r     <= 11'd0;
      eng_d_r     <= 32'd0;
      eng_cs_r    <= 1'b0;
      eng_oe_r    <= 1'b0;
      eng_wstrb_r <= 4'b0000;
    end else begin
      eng_cs_r    <= issue_wr_s | rd_issue_s | rd_hold_s;
      eng_oe_r    <= rd_issue_s | rd_hold_s;
      eng_wstrb_r <= issue_wr_s ? 4'b0001 : 4'b0000;
      if (issue_wr_s) begin
        eng_a_r <= {5'd0, wr_idx_s, 2'b00};
        eng_d_r <= {24'd0, wr_dat_s};
      end else if (rd_issue_s) begin
        eng_a_r <= {5'd0, IDX_FLAGS, 2'b00};
        eng_d_r <= eng_d_r;
      end else begin
        eng_a_r <= eng_a_r;
        eng_d_r <= eng_d_r;
      end
    end
  end

  // SD fetch watchdog, restarted whenever a fetch request is accepted.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      timer_r <= '0;
    end else if ((state_r == S_SDREQ) && sd_ack) begin
      timer_r <= '0;
    end else if (timer_run_s && !timer_max_s) begin
      timer_r <= timer_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end else begin
      timer_r <= timer_r;
    end
  end

  // Sequencer state machine with its registered status outputs.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_r   <= S_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      sd_req_r  <= 1'b0;
      sd_lba_r  <= 32'd0;
      rem_r     <= 9'd0;
      cur_lba_r <= 32'd0;
      first_r   <= 1'b0;
      hdone_r   <= 1'b0;
      pdone_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (fault_s) begin
        sd_req_r <= 1'b0;
        state_r  <= S_ERR0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              busy_r    <= 1'b1;
              first_r   <= 1'b1;
              hdone_r   <= 1'b0;
              pdone_r   <= 1'b0;
              cur_lba_r <= lba;
              rem_r     <= (count == 8'd0) ? 9'd256 : {1'b0, count};
              state_r   <= S_SDCFG;
            end else begin
              state_r   <= S_IDLE;
            end
          end
          S_SDCFG: begin
            // After the first sector every fetch targets the sector following the active one.
            sd_req_r <= 1'b1;
            sd_lba_r <= first_r ? cur_lba_r : cur_lba_r + 32'd1;
            state_r  <= S_SDREQ;
          end
          S_SDREQ: begin
            if (sd_ack) begin
              sd_req_r <= 1'b0;
              state_r  <= first_r ? S_SDWAIT : S_HWAIT;
            end else begin
              state_r  <= S_SDREQ;
            end
          end
          S_SDWAIT: state_r <= sd_done ? S_ARM0 : S_SDWAIT;
          S_ARM0:   state_r <= S_ARM1;
          S_ARM1:   state_r <= S_ARM2;
          S_ARM2:   state_r <= S_ARM3;
          S_ARM3: begin
            if (rem_r > 9'd1) begin
              first_r <= 1'b0;
              state_r <= S_SDCFG;
            end else begin
              state_r <= S_HWAIT;
            end
          end
          S_HWAIT: begin
            hdone_r <= hd_s;
            pdone_r <= pd_s;
            state_r <= hw_exit_s ? S_CLR : S_HWAIT;
          end
          S_CLR: begin
            rem_r     <= rem_r - 9'd1;
            cur_lba_r <= cur_lba_r + 32'd1;
            state_r   <= last_s ? S_FIN0 : S_FLIP;
          end
          S_FLIP: begin
            hdone_r <= 1'b0;
            pdone_r <= 1'b0;
            state_r <= S_ARM0;
          end
          S_FIN0: state_r <= S_FIN1;
          S_FIN1: begin
            done_r  <= 1'b1;
            state_r <= S_RET;
          end
          S_ERR0: state_r <= S_ERR1;
          S_ERR1: state_r <= S_ERR2;
          S_ERR2: begin
            err_r   <= 1'b1;
            state_r <= S_RET;
          end
          S_RET: begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            busy_r   <= 1'b0;
            sd_req_r <= 1'b0;
            state_r  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
